// File: rtl/pipeline_pkg.sv
// Shared pipeline constants and the IF-stage FSM state encoding.
package pipeline_pkg;

  localparam int unsigned NBITS     = 32;
  localparam logic [31:0] NOP_WORD  = 32'h0000_0000;
  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

endpackage

// File: rtl/instr_ram.sv
// Single-port instruction memory: clocked write, combinational read port.
// The read is registered by the IF/ID stage in the parent, giving a 1-cycle fetch.
module instr_ram #(
  parameter int unsigned NBITS      = 32,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [NBITS-1:0]      i_wdata,
  output logic [NBITS-1:0]      o_rdata
);

  logic [NBITS-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge i_clk) begin
    if (i_we) mem[i_addr] <= i_wdata;
  end

  assign o_rdata = mem[i_addr];

endmodule

// File: rtl/if_stage_imem.sv
// Instruction-fetch stage: program loader (bytes -> words), instruction memory,
// IF/ID register with flush/stall/enable handling and HALT detection.
module if_stage_imem #(
  parameter int unsigned      NBITS      = pipeline_pkg::NBITS,
  parameter int unsigned      ADDR_WIDTH = 8,
  parameter logic [NBITS-1:0] HALT_WORD  = NBITS'(pipeline_pkg::HALT_WORD)
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [NBITS-1:0]      i_pc,
  input  logic                  i_enable,
  input  logic                  i_stall,
  input  logic                  i_flush,
  input  logic                  i_run,
  input  logic                  i_clear,
  input  logic                  i_load_valid,
  input  logic [7:0]            i_load_byte,
  output logic [NBITS-1:0]      o_instr,
  output logic [NBITS-1:0]      o_pc_plus4,
  output logic                  o_valid,
  output logic                  o_halt,
  output logic [1:0]            o_state,
  output logic [ADDR_WIDTH:0]   o_load_words,
  output logic                  o_load_ovf
);
  import pipeline_pkg::*;

  state_t                state_q, state_d;
  logic [1:0]            byte_cnt_q;
  logic [23:0]           byte_buf_q;
  logic [ADDR_WIDTH-1:0] wr_ptr_q;
  logic [ADDR_WIDTH:0]   load_words_q;
  logic                  load_ovf_q;
  logic [NBITS-1:0]      instr_q, pc4_q;
  logic                  valid_q, halt_q;

  logic                  in_load, in_run, clear_go, load_wr, fetch_go, is_halt;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [NBITS-1:0]      ram_wdata, ram_rdata;

  assign in_load   = (state_q == ST_LOAD);
  assign in_run    = (state_q == ST_RUN);
  assign clear_go  = (state_q == ST_HALTED) && i_clear;
  assign load_wr   = in_load && i_load_valid && (byte_cnt_q == 2'd3);
  assign fetch_go  = in_run && !i_flush && !i_stall && i_enable;
  assign is_halt   = fetch_go && (ram_rdata == HALT_WORD);
  assign ram_addr  = in_load ? wr_ptr_q : i_pc[ADDR_WIDTH+1:2];
  assign ram_wdata = NBITS'({byte_buf_q, i_load_byte});

  instr_ram #(
    .NBITS      (NBITS),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (load_wr),
    .i_addr  (ram_addr),
    .i_wdata (ram_wdata),
    .o_rdata (ram_rdata)
  );

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) state_q <= ST_LOAD;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_LOAD:   if (i_run)   state_d = ST_RUN;
      ST_RUN:    if (is_halt) state_d = ST_HALTED;
      ST_HALTED: if (i_clear) state_d = ST_LOAD;
      default:                state_d = ST_LOAD;
    endcase
  end

  // Bytes shift in MSB-first; the 4th byte completes the word directly from the input.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      byte_cnt_q   <= '0;
      byte_buf_q   <= '0;
      wr_ptr_q     <= '0;
      load_words_q <= '0;
      load_ovf_q   <= 1'b0;
    end else if (clear_go) begin
      byte_cnt_q   <= '0;
      byte_buf_q   <= '0;
      wr_ptr_q     <= '0;
      load_words_q <= '0;
      load_ovf_q   <= 1'b0;
    end else if (in_load && i_load_valid) begin
      byte_cnt_q <= byte_cnt_q + 2'd1;
      byte_buf_q <= {byte_buf_q[15:0], i_load_byte};
      if (byte_cnt_q == 2'd3) begin
        wr_ptr_q     <= wr_ptr_q + 1'b1;
        load_words_q <= load_words_q + 1'b1;
        if (&wr_ptr_q) load_ovf_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      instr_q <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
      halt_q  <= 1'b0;
    end else if (in_run) begin
      if (i_flush) begin
        instr_q <= NBITS'(NOP_WORD);
        valid_q <= 1'b0;
      end else if (fetch_go) begin
        pc4_q <= i_pc + NBITS'(4);
        if (is_halt) begin
          instr_q <= NBITS'(NOP_WORD);
          valid_q <= 1'b0;
          halt_q  <= 1'b1;
        end else begin
          instr_q <= ram_rdata;
          valid_q <= 1'b1;
        end
      end
    end else if (clear_go) begin
      halt_q <= 1'b0;
    end
  end

  assign o_instr      = instr_q;
  assign o_pc_plus4   = pc4_q;
  assign o_valid      = valid_q;
  assign o_halt       = halt_q;
  assign o_state      = state_q;
  assign o_load_words = load_words_q;
  assign o_load_ovf   = load_ovf_q;

endmodule

// File: tb/tb_if_stage_imem.sv
// Directed bench for if_stage_imem: table-driven RUN vectors plus hand sequences
// for load, halt, overflow, clear and asynchronous reset.
module tb_if_stage_imem;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc;
  logic        en, stall, flush, run, clear, lvalid;
  logic [7:0]  lbyte;
  logic [31:0] instr, pc4;
  logic        valid, halt, ovf;
  logic [1:0]  state;
  logic [8:0]  words;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  always #5 clk = ~clk;

  if_stage_imem #(
    .NBITS      (32),
    .ADDR_WIDTH (8),
    .HALT_WORD  (32'hFFFF_FFFF)
  ) dut (
    .i_clk        (clk),
    .i_reset      (rst_n),
    .i_pc         (pc),
    .i_enable     (en),
    .i_stall      (stall),
    .i_flush      (flush),
    .i_run        (run),
    .i_clear      (clear),
    .i_load_valid (lvalid),
    .i_load_byte  (lbyte),
    .o_instr      (instr),
    .o_pc_plus4   (pc4),
    .o_valid      (valid),
    .o_halt       (halt),
    .o_state      (state),
    .o_load_words (words),
    .o_load_ovf   (ovf)
  );

  typedef struct {
    logic [31:0] pc;
    logic        en, stall, flush;
    logic [31:0] instr, pc4;
    logic        valid;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_byte(input logic [7:0] b);
    lvalid = 1'b1;
    lbyte  = b;
    step();
    lvalid = 1'b0;
  endtask

  task automatic load_word(input logic [31:0] w);
    for (int k = 3; k >= 0; k--) load_byte(w[k*8 +: 8]);
  endtask

  task automatic pulse_run();
    run = 1'b1;
    step();
    run = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a);
    pc = a; en = 1'b1; stall = 1'b0; flush = 1'b0;
    step();
  endtask

  function automatic logic [31:0] big_word(input int unsigned i);
    if (i == 2) return 32'hFFFF_FFFF;
    return 32'h1000_0000 + i;
  endfunction

  initial begin
    vecs[0]  = '{32'h0000_0000, 1, 0, 0, 32'h1122_3344, 32'h0000_0004, 1};
    vecs[1]  = '{32'h0000_0004, 1, 0, 0, 32'h5566_7788, 32'h0000_0008, 1};
    vecs[2]  = '{32'h0000_0000, 1, 1, 0, 32'h5566_7788, 32'h0000_0008, 1};
    vecs[3]  = '{32'h0000_0040, 1, 1, 0, 32'h5566_7788, 32'h0000_0008, 1};
    vecs[4]  = '{32'h0000_0008, 1, 1, 0, 32'h5566_7788, 32'h0000_0008, 1};
    vecs[5]  = '{32'h0000_0000, 0, 0, 0, 32'h5566_7788, 32'h0000_0008, 1};
    vecs[6]  = '{32'h0000_0400, 1, 0, 0, 32'h1122_3344, 32'h0000_0404, 1};
    vecs[7]  = '{32'h0000_0C05, 1, 0, 0, 32'h5566_7788, 32'h0000_0C09, 1};
    vecs[8]  = '{32'h0000_0000, 1, 1, 1, 32'h0000_0000, 32'h0000_0C09, 0};
    vecs[9]  = '{32'h0000_0004, 1, 0, 0, 32'h5566_7788, 32'h0000_0008, 1};
    vecs[10] = '{32'h0000_0000, 0, 0, 1, 32'h0000_0000, 32'h0000_0008, 0};
    vecs[11] = '{32'h0000_0008, 1, 0, 1, 32'h0000_0000, 32'h0000_0008, 0};

    rst_n = 1'b0; pc = '0; en = 1'b0; stall = 1'b0; flush = 1'b0;
    run = 1'b0; clear = 1'b0; lvalid = 1'b0; lbyte = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst instr", instr, 32'h0);
    chk("rst pc4",   pc4,   32'h0);
    chk("rst valid", {31'b0, valid}, 32'd0);
    chk("rst halt",  {31'b0, halt},  32'd0);
    chk("rst state", {30'b0, state}, 32'd0);
    chk("rst words", {23'b0, words}, 32'd0);
    chk("rst ovf",   {31'b0, ovf},   32'd0);
    rst_n = 1'b1;
    step();

    // Load: two data words, a HALT word at index 2, then a 3-byte tail that must not commit.
    for (int b = 1; b <= 8; b++) load_byte(8'((b << 4) | b));
    chk("load words2", {23'b0, words}, 32'd2);
    load_word(32'hFFFF_FFFF);
    load_byte(8'hAA); load_byte(8'hBB); load_byte(8'hCC);
    chk("tail no commit", {23'b0, words}, 32'd3);
    pulse_run();
    chk("run state", {30'b0, state}, 32'd1);
    chk("run words", {23'b0, words}, 32'd3);

    for (int i = 0; i < 12; i++) begin
      pc = vecs[i].pc; en = vecs[i].en; stall = vecs[i].stall; flush = vecs[i].flush;
      step();
      chk($sformatf("vec%0d instr", i), instr, vecs[i].instr);
      chk($sformatf("vec%0d pc4", i),   pc4,   vecs[i].pc4);
      chk($sformatf("vec%0d valid", i), {31'b0, valid}, {31'b0, vecs[i].valid});
      chk($sformatf("vec%0d halt", i),  {31'b0, halt},  32'd0);
      chk($sformatf("vec%0d state", i), {30'b0, state}, 32'd1);
    end

    fetch(32'h0000_0008);
    chk("halt flag",  {31'b0, halt},  32'd1);
    chk("halt state", {30'b0, state}, 32'd2);
    chk("halt valid", {31'b0, valid}, 32'd0);
    chk("halt instr", instr, 32'h0);

    pulse_run();
    load_word(32'h0BAD_0BAD);
    fetch(32'h0000_0000);
    chk("halted ignore state", {30'b0, state}, 32'd2);
    chk("halted ignore instr", instr, 32'h0);
    chk("halted ignore words", {23'b0, words}, 32'd3);
    en = 1'b0;

    pulse_clear();
    chk("clear state", {30'b0, state}, 32'd0);
    chk("clear halt",  {31'b0, halt},  32'd0);
    chk("clear words", {23'b0, words}, 32'd0);

    // Overflow: MEM_DEPTH+1 words, the last one lands on index 0.
    for (int unsigned i = 0; i < 255; i++) load_word(big_word(i));
    chk("ovf before wrap", {31'b0, ovf}, 32'd0);
    for (int unsigned i = 255; i < 257; i++) load_word(big_word(i));
    chk("ovf set",   {31'b0, ovf},   32'd1);
    chk("ovf words", {23'b0, words}, 32'd257);
    pulse_run();
    fetch(32'h0000_0000);
    chk("wrap word0", instr, 32'h1000_0100);
    fetch(32'hFFFF_FFFC);
    chk("top word",  instr, 32'h1000_00FF);
    chk("pc4 wraps", pc4,   32'h0);
    fetch(32'h0000_0008);
    chk("halt2 state", {30'b0, state}, 32'd2);
    en = 1'b0;
    pulse_clear();
    chk("clear2 words", {23'b0, words}, 32'd0);
    chk("clear2 ovf",   {31'b0, ovf},   32'd0);

    // Asynchronous reset between edges while running.
    pulse_run();
    fetch(32'h0000_0004);
    chk("pre-rst instr", instr, 32'h1000_0001);
    #2 rst_n = 1'b0;
    #1;
    chk("async instr", instr, 32'h0);
    chk("async pc4",   pc4,   32'h0);
    chk("async valid", {31'b0, valid}, 32'd0);
    chk("async state", {30'b0, state}, 32'd0);
    #1 rst_n = 1'b1;
    en = 1'b0;
    step();
    pulse_run();
    fetch(32'h0000_0000);
    chk("post-rst word0",  instr, 32'h1000_0100);
    fetch(32'h0000_03FC);
    chk("post-rst word255", instr, 32'h1000_00FF);
    chk("post-rst pc4",     pc4,   32'h0000_0400);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
